div_seq: RTL and testbench

//  Multi-cycle divider sequencer for the execute stage. It serves the DIV and DIVU

---
 rtl/div_seq_pkg.sv | 22 ++
 rtl/div_seq_step.sv | 25 ++
 rtl/div_seq.sv | 139 +++++++++++++
 tb/tb_div_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state codes, handshake
// levels and the execute-stage opcodes that select the divider.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam int DoubleRegBus = 64;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dvd_next
);

    logic [WIDTH:0] shifted;
    logic           fits;

    // The shifted remainder can reach WIDTH+1 bits, so the fit test is a full
    // magnitude compare rather than the sign of a WIDTH+1-bit difference.
    always_comb begin
        shifted  = {rem, dvd[WIDTH-1]};
        fits     = (shifted >= {1'b0, divisor});
        rem_next = fits ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
        dvd_next = {dvd[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: one quotient bit per cycle, result held as
// {remainder, quotient} while the execute stage keeps start_i asserted.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    import div_seq_pkg::*;

    localparam int CntW = $clog2(WIDTH + 1);

    div_state_t         state, state_n;
    logic [CntW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0]   rem, rem_n;
    logic [WIDTH-1:0]   dvd, dvd_n;
    logic [WIDTH-1:0]   dsr, dsr_n;
    logic               qneg, qneg_n;
    logic               rneg, rneg_n;
    logic               ready_n;
    logic [2*WIDTH-1:0] result_n;

    logic [WIDTH-1:0]   step_rem, step_dvd;
    logic [WIDTH-1:0]   op1_abs, op2_abs;
    logic [WIDTH-1:0]   rem_fix, quo_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd      (dvd),
        .divisor  (dsr),
        .rem_next (step_rem),
        .dvd_next (step_dvd)
    );

    // Signed divides run on magnitudes; the most negative value maps to itself,
    // which yields the architected wrap for -2^(W-1) / -1.
    assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    assign rem_fix = rneg ? (~rem + 1'b1) : rem;
    assign quo_fix = qneg ? (~dvd + 1'b1) : dvd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rem      <= rem_n;
            dvd      <= dvd_n;
            dsr      <= dsr_n;
            qneg     <= qneg_n;
            rneg     <= rneg_n;
            ready_o  <= ready_n;
            result_o <= result_n;
        end
    end

    // The dividend register doubles as the quotient: each step shifts a
    // dividend bit out of the top and a quotient bit in at the bottom.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rem_n    = rem;
        dvd_n    = dvd;
        dsr_n    = dsr;
        qneg_n   = qneg;
        rneg_n   = rneg;
        ready_n  = ready_o;
        result_n = result_o;

        case (state)
            DivFree: begin
                ready_n  = DivResultNotReady;
                result_n = '0;
                if (start_i == DivStart && !annul_i) begin
                    dvd_n   = op1_abs;
                    dsr_n   = op2_abs;
                    rem_n   = '0;
                    cnt_n   = '0;
                    qneg_n  = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    rneg_n  = signed_div_i & opdata1_i[WIDTH-1];
                    state_n = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                if (annul_i) begin
                    state_n = DivFree;
                end else begin
                    state_n  = DivEnd;
                    ready_n  = DivResultReady;
                    result_n = '0;
                end
            end
            DivOn: begin
                if (annul_i) begin
                    state_n  = DivFree;
                    cnt_n    = '0;
                    ready_n  = DivResultNotReady;
                    result_n = '0;
                end else if (cnt == CntW'(WIDTH)) begin
                    state_n  = DivEnd;
                    ready_n  = DivResultReady;
                    result_n = {rem_fix, quo_fix};
                end else begin
                    rem_n = step_rem;
                    dvd_n = step_dvd;
                    cnt_n = cnt + CntW'(1);
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_n  = DivFree;
                    ready_n  = DivResultNotReady;
                    result_n = '0;
                end
            end
            default: begin
                state_n = DivFree;
            end
        endcase
    end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expected results are queued as each divide is
// launched and compared when ready_o rises.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;
    bit scramble = 0;
    logic [63:0] scoreboard[$];

    div_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference built on the language's own truncating signed division.
    function automatic logic [63:0] modelDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sbv, q, r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa  = a;
        sbv = b;
        q   = sa / sbv;
        r   = sa % sbv;
        return {r, q};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] expected);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        scoreboard.push_back(expected);
    endtask

    // Consumes the acceptance edge, then counts edges until ready_o.
    task automatic waitResult(input string tag, input int expLat);
        int cyc = 0;
        bit got = 0;
        logic [63:0] exp;
        @(posedge clk); #1;
        while (cyc < 100 && !got) begin
            @(posedge clk); #1;
            cyc++;
            if (ready_o) got = 1;
            else if (scramble) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
        end
        if (!got) begin
            checkOutput({tag, "_timeout"}, {63'd0, ready_o}, 64'd1);
        end else begin
            checkOutput({tag, "_latency"}, 64'(cyc), 64'(expLat));
            if (scoreboard.size() == 0) begin
                checkOutput({tag, "_sb_empty"}, result_o, 64'hx);
            end else begin
                exp = scoreboard.pop_front();
                checkOutput({tag, "_result"}, result_o, exp);
            end
        end
    endtask

    task automatic releaseStart(input string tag);
        start_i = 1'b0;
        @(posedge clk); #1;
        checkOutput({tag, "_ready_fall"}, {63'd0, ready_o}, 64'd0);
        checkOutput({tag, "_result_clr"}, result_o, 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        start_i = 1'b0; annul_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", {63'd0, ready_o}, 64'd0);
        checkOutput("reset_result", result_o, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(0, 32'd100, 32'd7, {32'd2, 32'd14});
        waitResult("divu_100_7", 33);
        held = result_o;
        @(posedge clk); #1;
        checkOutput("done_hold_ready", {63'd0, ready_o}, 64'd1);
        checkOutput("done_hold_result", result_o, held);
        releaseStart("divu_100_7");

        applyStimulus(1, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        waitResult("div_m7_2", 33);
        releaseStart("div_m7_2");

        applyStimulus(1, 32'd7, -32'sd2, {32'd1, 32'hFFFF_FFFD});
        waitResult("div_7_m2", 33);
        releaseStart("div_7_m2");

        applyStimulus(1, 32'd5, 32'd0, 64'd0);
        waitResult("div_by_zero", 1);
        releaseStart("div_by_zero");

        // Abandon a divide part-way; the aborted entry is dropped from the queue.
        applyStimulus(0, 32'hFFFF_FFFF, 32'd3, {32'd0, 32'h5555_5555});
        repeat (11) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk); #1;
        checkOutput("annul_ready", {63'd0, ready_o}, 64'd0);
        checkOutput("annul_result", result_o, 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        void'(scoreboard.pop_front());
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("annul_idle_ready", {63'd0, ready_o}, 64'd0);
        end
        applyStimulus(0, 32'hFFFF_FFFF, 32'd3, {32'd0, 32'h5555_5555});
        waitResult("after_annul", 33);
        releaseStart("after_annul");

        applyStimulus(1, -32'sd1000, 32'd7, modelDiv(1, -32'sd1000, 32'd7));
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrun_rst_ready", {63'd0, ready_o}, 64'd0);
        checkOutput("midrun_rst_result", result_o, 64'd0);
        rst = 1'b0;
        start_i = 1'b0;
        void'(scoreboard.pop_front());
        @(posedge clk); #1;

        scramble = 1;
        applyStimulus(0, 32'd100, 32'd7, {32'd2, 32'd14});
        waitResult("operand_change", 33);
        scramble = 0;
        releaseStart("operand_change");

        applyStimulus(1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
        waitResult("signed_overflow", 33);
        releaseStart("signed_overflow");

        applyStimulus(0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF});
        waitResult("divu_max_1", 33);
        releaseStart("divu_max_1");

        for (int i = 0; i < 6; i++) begin
            bit sgn;
            logic [31:0] a, b;
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 31);
            applyStimulus(sgn, a, b, modelDiv(sgn, a, b));
            waitResult($sformatf("random_%0d", i), (b == 32'd0) ? 1 : 33);
            releaseStart($sformatf("random_%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
